note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Upstream control stage for audio_multichannel. Plays a programmable note table and drives one
//  channel's enable/frequency inputs (ch_en_o -> chN_en_i, ch_freq_o -> chN_freq_i).
//  Replaces hand-timed stimulus with a tick-based score player. One instance per channel.
// PARAMETERS
//  NOTE_COUNT  32       note table depth (entries)
//  TICK_DIV    1562500  clk cycles per tick (1/8 s at 12.5 MHz)
//  FREQ_W      16       phase-increment width; matches chN_freq_i
//  DUR_W       8        duration field width, in ticks
// PORTS
//  clk_i      in   1                     single clock
//  rst_i      in   1                     synchronous active-high reset
//  wr_en_i    in   1                     note-table write strobe
//  wr_addr_i  in   $clog2(NOTE_COUNT)    write address
//  wr_data_i  in   FREQ_W+DUR_W+3        entry {last, stacc, rest, dur, freq}
//  start_i    in   1                     begin playback at entry 0 (IDLE only)
//  stop_i     in   1                     abort playback
//  loop_i     in   1                     on the last entry, wrap to entry 0 instead of finishing
//  ch_en_o    out  1                     channel enable
//  ch_freq_o  out  FREQ_W                channel phase increment
//  note_idx_o out  $clog2(NOTE_COUNT)    index of the entry now playing
//  busy_o     out  1                     high in FETCH/PLAY
//  done_o     out  1                     1-cycle pulse when a non-looped score ends
// BEHAVIOUR
//  Reset (sync, rst_i=1): state=IDLE; all outputs 0; table contents undefined, not cleared.
//  Table: sync-write RAM with 1-cycle registered read.
//   - Writes are accepted only while busy_o=0.
//   - Writes while busy are dropped.
//  FSM IDLE -> FETCH -> PLAY -> (FETCH | IDLE):
//   IDLE:  start_i=1 -> FETCH with addr=0.
//   FETCH: 1 cycle, read issued.
//    - Outputs keep their previous values.
//    - Tick prescaler and duration counter are cleared.
//   PLAY:  entered on the edge after FETCH; outputs load on that edge.
//    - ch_freq_o=freq, unless rest=1; then ch_freq_o holds its previous value.
//    - ch_en_o = ~rest. note_idx_o = addr.
//  Tick: prescaler counts 0..TICK_DIV-1; tick pulse at TICK_DIV-1, then wraps to 0.
//  Duration: counter increments on each tick.
//   - Effective dur = (dur==0) ? 1 : dur.
//   - The note ends on the tick where count == eff_dur-1.
//  Staccato (stacc=1, rest=0): ch_en_o drops to 0 for the final tick of the note.
//   - With eff_dur=1, en is high for 0 ticks.
//  Note end:
//   - last=0 -> FETCH addr+1.
//   - last=1, loop_i=1 -> FETCH addr 0.
//   - last=1, loop_i=0 -> IDLE; ch_en_o=0 and done_o=1 on the same edge.
//   - addr reaching NOTE_COUNT-1 with last=0 wraps to 0.
//  Latency: start_i sampled at edge N -> FETCH at N+1 -> PLAY outputs visible after edge N+2.
//   - A note occupies eff_dur*TICK_DIV PLAY cycles plus 1 FETCH cycle.
//  stop_i: from any state -> IDLE at the next edge; ch_en_o=0; done_o stays 0.
//   - ch_freq_o and note_idx_o hold their values.
//   - If stop_i and start_i are both high, stop wins.
//  start_i while busy: ignored. loop_i is sampled only at the note-end decision.
// STRUCTURE
//  audio_seq_pkg (shared):
//   - note_entry_t packed struct {last, stacc, rest, dur, freq}.
//   - seq_state_e {IDLE, FETCH, PLAY}.
//   - Note constants G4=16'd4208, DS4=16'd3339, AS4=16'd5005.
//  Sub-module seq_tick_gen: prescaler with sync clear; outputs a tick pulse.
//  Note RAM and FSM live in note_sequencer.
// TESTING (bench overrides TICK_DIV=4)
//  1 Load {G4,dur2}, {DS4,dur1,last}; start at N.
//    -> en=1, freq=4208 after edge N+2, for 8 cycles.
//    -> 1 FETCH cycle, then freq=3339 for 4 cycles.
//    -> done_o pulse; busy_o=0.
//  2 Rest entry dur3 after G4.
//    -> ch_en_o=0 for 12 cycles; ch_freq_o stays 4208.
//  3 Staccato G4 dur2.
//    -> en=1 for 4 cycles, en=0 for 4 cycles, then FETCH.
//  4 loop_i=1 with a 2-entry score.
//    -> after the last entry, note_idx_o=0 again; done_o never pulses; busy_o stays 1.
//  5 stop_i mid-note, then rst_i mid-note.
//    -> stop: next edge en=0, busy=0, done=0.
//    -> reset: all outputs 0.
//  6 Write while busy, then play.
//    -> table unchanged.
//    -> dur=0 entry plays exactly 4 cycles.
//    -> start_i+stop_i together: stays IDLE.

Source files
------------

// File: rtl/audio_seq_pkg.sv
// -----------------------------------------------------------------------------
// audio_seq_pkg
// Shared types and constants for the note sequencer that feeds one channel of
// audio_multichannel.
//   note_entry_t : one note-table word {last, stacc, rest, dur, freq}
//   seq_state_e  : player FSM states
//   G4/DS4/AS4   : phase increments for commonly used notes
// -----------------------------------------------------------------------------
package audio_seq_pkg;

  localparam int unsigned SEQ_FREQ_W = 16;
  localparam int unsigned SEQ_DUR_W  = 8;

  typedef struct packed {
    logic                  last;   // final entry of the score
    logic                  stacc;  // release the channel for the final tick
    logic                  rest;   // silent note, frequency left untouched
    logic [SEQ_DUR_W-1:0]  dur;    // length in ticks, 0 is treated as 1
    logic [SEQ_FREQ_W-1:0] freq;   // phase increment for the channel
  } note_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } seq_state_e;

  localparam logic [SEQ_FREQ_W-1:0] G4  = 16'd4208;
  localparam logic [SEQ_FREQ_W-1:0] DS4 = 16'd3339;
  localparam logic [SEQ_FREQ_W-1:0] AS4 = 16'd5005;

  // Builds a table word from its fields.
  function automatic note_entry_t make_note(input logic [SEQ_FREQ_W-1:0] freq,
                                            input logic [SEQ_DUR_W-1:0]  dur,
                                            input logic                  rest,
                                            input logic                  stacc,
                                            input logic                  last);
    note_entry_t e;
    e.freq  = freq;
    e.dur   = dur;
    e.rest  = rest;
    e.stacc = stacc;
    e.last  = last;
    return e;
  endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// -----------------------------------------------------------------------------
// seq_tick_gen
// Tick prescaler: counts 0..TICK_DIV-1 and pulses tick_o on the last count,
// then wraps. A synchronous clear holds the count at 0 and masks the pulse.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous clear (count restarts at 0 on the next cycle)
//   tick_o : 1-cycle pulse every TICK_DIV cycles while not cleared
// -----------------------------------------------------------------------------
module seq_tick_gen #(
  parameter int unsigned TICK_DIV = 1562500
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned     CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick_o = w_wrap && !clr_i;

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Tick-based score player driving one channel's enable and phase increment.
// A small note table is written while idle; start_i plays it from entry 0.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   wr_en_i    : note-table write strobe (ignored while busy_o=1)
//   wr_addr_i  : write address
//   wr_data_i  : entry {last, stacc, rest, dur, freq}
//   start_i    : begin playback at entry 0 (only from idle)
//   stop_i     : abort playback, wins over start_i
//   loop_i     : on the last entry wrap to entry 0 instead of finishing
//   ch_en_o    : channel enable
//   ch_freq_o  : channel phase increment
//   note_idx_o : index of the entry now playing
//   busy_o     : high while fetching or playing
//   done_o     : 1-cycle pulse when a non-looped score ends
// -----------------------------------------------------------------------------
module note_sequencer
  import audio_seq_pkg::*;
#(
  parameter int unsigned NOTE_COUNT = 32,
  parameter int unsigned TICK_DIV   = 1562500,
  parameter int unsigned FREQ_W     = SEQ_FREQ_W,
  parameter int unsigned DUR_W      = SEQ_DUR_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_en_i,
  input  logic [$clog2(NOTE_COUNT)-1:0] wr_addr_i,
  input  logic [FREQ_W+DUR_W+2:0]       wr_data_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic                          loop_i,
  output logic                          ch_en_o,
  output logic [FREQ_W-1:0]             ch_freq_o,
  output logic [$clog2(NOTE_COUNT)-1:0] note_idx_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned   AW        = $clog2(NOTE_COUNT);
  localparam int unsigned   EW        = FREQ_W + DUR_W + 3;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NOTE_COUNT - 1);

  logic [EW-1:0]     r_mem [NOTE_COUNT];
  logic [EW-1:0]     r_rd_data;
  seq_state_e        r_state, w_state_nxt;
  logic [AW-1:0]     r_addr, w_addr_nxt;
  logic [DUR_W-1:0]  r_dur_cnt;
  logic              r_start_q;
  logic              r_en, r_done;
  logic [FREQ_W-1:0] r_freq;
  logic [AW-1:0]     r_idx;

  logic              w_tick, w_tick_clr;
  logic              w_busy, w_load, w_finish, w_stacc_drop;
  logic              w_note_end, w_dur_final, w_dur_pen;
  logic [FREQ_W-1:0] w_freq;
  logic [DUR_W-1:0]  w_dur, w_eff_dur;
  logic              w_rest, w_stacc, w_last;

  // Fields of the entry being fetched or played.
  assign w_freq    = r_rd_data[FREQ_W-1:0];
  assign w_dur     = r_rd_data[FREQ_W +: DUR_W];
  assign w_rest    = r_rd_data[FREQ_W+DUR_W];
  assign w_stacc   = r_rd_data[FREQ_W+DUR_W+1];
  assign w_last    = r_rd_data[FREQ_W+DUR_W+2];
  assign w_eff_dur = (w_dur == '0) ? DUR_W'(1) : w_dur;

  // Final tick of the note, and the tick just before it (staccato release).
  assign w_dur_final = (r_dur_cnt == w_eff_dur - DUR_W'(1));
  assign w_dur_pen   = (w_eff_dur != DUR_W'(1)) && (r_dur_cnt == w_eff_dur - DUR_W'(2));
  assign w_note_end  = (r_state == PLAY) && w_tick && w_dur_final;

  // Prescaler and duration counter both restart for every note.
  assign w_tick_clr = (r_state != PLAY);

  seq_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (w_tick_clr),
    .tick_o (w_tick)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // start_i is registered first, so playback begins two edges after the
  // request; the request only counts when the player is idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_start_q <= start_i && !stop_i && (r_state == IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and next fetch address
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    if (stop_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_start_q) begin
            w_state_nxt = FETCH;
            w_addr_nxt  = '0;
          end
        end
        FETCH: w_state_nxt = PLAY;
        PLAY: begin
          if (w_note_end) begin
            if (!w_last) begin
              w_state_nxt = FETCH;
              w_addr_nxt  = (r_addr == LAST_ADDR) ? '0 : r_addr + AW'(1);
            end else if (loop_i) begin
              w_state_nxt = FETCH;
              w_addr_nxt  = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy       = (r_state != IDLE);
    w_load       = (r_state == FETCH) && !stop_i;
    w_finish     = w_note_end && w_last && !loop_i && !stop_i;
    w_stacc_drop = (r_state == PLAY) && w_tick && w_stacc && !w_rest &&
                   w_dur_pen && !stop_i;
  end

  // ---------------------------------------------------------------------------
  // Note table. The read address is the next fetch address, so the entry is
  // already registered during FETCH and can be loaded on the PLAY edge.
  // ---------------------------------------------------------------------------
  // NOTE: the table is deliberately left out of reset; contents are undefined
  // until written, which lets it map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !w_busy) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
    r_rd_data <= r_mem[w_addr_nxt];
  end

  // Duration counter: ticks elapsed within the current note.
  always_ff @(posedge clk_i) begin
    if (rst_i || (r_state != PLAY)) begin
      r_dur_cnt <= '0;
    end else if (w_tick) begin
      r_dur_cnt <= r_dur_cnt + DUR_W'(1);
    end
  end

  // Channel outputs. Rests keep the previous frequency; FETCH holds everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_en   <= 1'b0;
      r_freq <= '0;
      r_idx  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop_i) begin
        r_en <= 1'b0;
      end else if (w_load) begin
        // A one-tick staccato note is released for its whole length.
        r_en  <= !w_rest && !(w_stacc && (w_eff_dur == DUR_W'(1)));
        r_idx <= r_addr;
        if (!w_rest) begin
          r_freq <= w_freq;
        end
      end else if (w_finish) begin
        r_en   <= 1'b0;
        r_done <= 1'b1;
      end else if (w_stacc_drop) begin
        r_en <= 1'b0;
      end
    end
  end

  assign ch_en_o    = r_en;
  assign ch_freq_o  = r_freq;
  assign note_idx_o = r_idx;
  assign busy_o     = w_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
  import audio_seq_pkg::*;

  localparam int unsigned NC = 32;
  localparam int unsigned TD = 4;
  localparam int unsigned AW = 5;
  localparam int unsigned EW = 27;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [EW-1:0] wr_data_i = '0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          loop_i = 1'b0;
  logic          ch_en_o;
  logic [15:0]   ch_freq_o;
  logic [AW-1:0] note_idx_o;
  logic          busy_o;
  logic          done_o;

  typedef struct packed {
    logic          en;
    logic [15:0]   freq;
    logic [AW-1:0] idx;
    logic          busy;
    logic          done;
  } obs_t;

  note_entry_t tbl [NC];   // what the table should hold
  obs_t        exp_q[$];   // expected outputs, one per cycle after the start edge
  obs_t        m_out;      // expected outputs of the DUT right now
  int          errors = 0;
  int          checks = 0;

  always #5 clk_i = ~clk_i;

  note_sequencer #(
    .NOTE_COUNT (NC),
    .TICK_DIV   (TD)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .loop_i     (loop_i),
    .ch_en_o    (ch_en_o),
    .ch_freq_o  (ch_freq_o),
    .note_idx_o (note_idx_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.en   = ch_en_o;
    o.freq = ch_freq_o;
    o.idx  = note_idx_o;
    o.busy = busy_o;
    o.done = done_o;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("en=%b freq=%0d idx=%0d busy=%b done=%b",
                     o.en, o.freq, o.idx, o.busy, o.done);
  endfunction

  function automatic note_entry_t mk(input logic [15:0] f, input int d,
                                     input bit rest, input bit stacc, input bit last);
    return make_note(f, 8'(d), rest, stacc, last);
  endfunction

  task automatic write_entry(input int a, input note_entry_t e);
    wr_en_i   = 1'b1;
    wr_addr_i = AW'(a);
    wr_data_i = e;
    tick();
    wr_en_i   = 1'b0;
    tbl[a]    = e;
  endtask

  // Reference model: plays the score note by note from the table contents.
  // Entry 0 of the trace is the cycle after the start edge (still idle),
  // entry 1 the FETCH cycle, then each note's PLAY cycles and the FETCH after.
  function automatic void build_trace(input bit loop, input int max_len);
    obs_t        o;
    note_entry_t e;
    int          addr;
    int          eff;
    o    = m_out;
    addr = 0;
    exp_q.delete();
    o.busy = 1'b0; o.done = 1'b0;
    exp_q.push_back(o);
    o.busy = 1'b1;
    exp_q.push_back(o);
    while (exp_q.size() < max_len) begin
      e   = tbl[addr];
      eff = (e.dur == 0) ? 1 : int'(e.dur);
      if (!e.rest) o.freq = e.freq;
      o.idx = addr[AW-1:0];
      for (int t = 0; t < eff; t++) begin
        for (int c = 0; c < TD; c++) begin
          o.en = !e.rest && !(e.stacc && (t == eff - 1));
          exp_q.push_back(o);
        end
      end
      if (e.last && !loop) begin
        o.en = 1'b0; o.busy = 1'b0; o.done = 1'b1;
        exp_q.push_back(o);
        o.done = 1'b0;
        exp_q.push_back(o);
        break;
      end
      addr = e.last ? 0 : (addr + 1) % NC;
      exp_q.push_back(o);
    end
  endfunction

  task automatic test_reset();
    obs_t o;
    rst_i = 1'b1;
    tick();
    tick();
    o = sample();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_held: got %s want all zero", fmt(o));
    end
    rst_i = 1'b0;
    tick();
    o = sample();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_released: got %s want all zero", fmt(o));
    end
    m_out = '0;
  endtask

  task automatic test_basic();
    obs_t o;
    write_entry(0, mk(G4, 2, 0, 0, 0));
    write_entry(1, mk(DS4, 1, 0, 0, 1));
    build_trace(0, 100);
    start_i = 1'b1; tick(); start_i = 1'b0;
    foreach (exp_q[k]) begin
      if (k > 0) tick();
      o = sample();
      checks++;
      if (o !== exp_q[k]) begin
        errors++;
        $display("FAIL basic cyc%0d: got %s want %s", k, fmt(o), fmt(exp_q[k]));
      end
    end
    m_out = exp_q[$];
  endtask

  task automatic test_rest();
    obs_t o;
    write_entry(0, mk(G4, 1, 0, 0, 0));
    write_entry(1, mk(16'($urandom), 3, 1, 0, 0));
    write_entry(2, mk(AS4, 1, 0, 0, 1));
    build_trace(0, 100);
    start_i = 1'b1; tick(); start_i = 1'b0;
    foreach (exp_q[k]) begin
      if (k > 0) tick();
      o = sample();
      checks++;
      if (o !== exp_q[k]) begin
        errors++;
        $display("FAIL rest cyc%0d: got %s want %s", k, fmt(o), fmt(exp_q[k]));
      end
    end
    m_out = exp_q[$];
  endtask

  task automatic test_staccato();
    obs_t o;
    write_entry(0, mk(G4, 2, 0, 1, 0));
    write_entry(1, mk(DS4, 1, 0, 1, 1));
    build_trace(0, 100);
    start_i = 1'b1; tick(); start_i = 1'b0;
    foreach (exp_q[k]) begin
      if (k > 0) tick();
      o = sample();
      checks++;
      if (o !== exp_q[k]) begin
        errors++;
        $display("FAIL staccato cyc%0d: got %s want %s", k, fmt(o), fmt(exp_q[k]));
      end
    end
    m_out = exp_q[$];
  endtask

  task automatic test_loop();
    obs_t o;
    obs_t e;
    write_entry(0, mk(G4, 1, 0, 0, 0));
    write_entry(1, mk(DS4, 1, 0, 0, 1));
    loop_i = 1'b1;
    build_trace(1, 24);
    start_i = 1'b1; tick(); start_i = 1'b0;
    foreach (exp_q[k]) begin
      if (k > 0) tick();
      o = sample();
      checks++;
      if (o !== exp_q[k]) begin
        errors++;
        $display("FAIL loop cyc%0d: got %s want %s", k, fmt(o), fmt(exp_q[k]));
      end
      // A start request while playing must be ignored.
      start_i = (k == 5);
    end
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    loop_i = 1'b0;
    e = exp_q[$];
    e.en = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    o = sample();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL loop_stop: got %s want %s", fmt(o), fmt(e));
    end
    m_out = e;
  endtask

  task automatic test_stop_reset();
    obs_t o;
    obs_t e;
    write_entry(0, mk(G4, 3, 0, 0, 1));
    build_trace(0, 100);
    start_i = 1'b1; tick(); start_i = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      o = sample();
      checks++;
      if (o !== exp_q[k]) begin
        errors++;
        $display("FAIL stop_pre cyc%0d: got %s want %s", k, fmt(o), fmt(exp_q[k]));
      end
    end
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    e = exp_q[5];
    e.en = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stop_after cyc%0d: got %s want %s", k, fmt(o), fmt(e));
      end
    end
    m_out = e;
    build_trace(0, 100);
    start_i = 1'b1; tick(); start_i = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      o = sample();
      checks++;
      if (o !== exp_q[k]) begin
        errors++;
        $display("FAIL reset_pre cyc%0d: got %s want %s", k, fmt(o), fmt(exp_q[k]));
      end
    end
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    o = sample();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_mid: got %s want all zero", fmt(o));
    end
    m_out = '0;
  endtask

  task automatic test_write_busy();
    obs_t o;
    obs_t e;
    write_entry(0, mk(AS4, 0, 0, 0, 0));
    write_entry(1, mk(G4, 1, 0, 0, 1));
    build_trace(0, 100);
    start_i = 1'b1; tick(); start_i = 1'b0;
    foreach (exp_q[k]) begin
      if (k > 0) tick();
      o = sample();
      checks++;
      if (o !== exp_q[k]) begin
        errors++;
        $display("FAIL wr_busy cyc%0d: got %s want %s", k, fmt(o), fmt(exp_q[k]));
      end
      // Writes during PLAY of entry 0; the shadow table is left untouched.
      wr_en_i   = (k == 3) || (k == 4);
      wr_addr_i = (k == 3) ? AW'(1) : AW'(0);
      wr_data_i = mk(DS4, 3, 0, 1, 1);
    end
    wr_en_i = 1'b0;
    m_out = exp_q[$];
    // Replay: the table must still hold the original score.
    build_trace(0, 100);
    start_i = 1'b1; tick(); start_i = 1'b0;
    foreach (exp_q[k]) begin
      if (k > 0) tick();
      o = sample();
      checks++;
      if (o !== exp_q[k]) begin
        errors++;
        $display("FAIL wr_replay cyc%0d: got %s want %s", k, fmt(o), fmt(exp_q[k]));
      end
    end
    m_out = exp_q[$];
    // start and stop together: stop wins.
    start_i = 1'b1; stop_i = 1'b1; tick(); start_i = 1'b0; stop_i = 1'b0;
    e = m_out;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL start_stop cyc%0d: got %s want %s", k, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_wrap();
    obs_t o;
    obs_t e;
    for (int a = 0; a < NC; a++) begin
      write_entry(a, mk(16'($urandom), 1, 0, 0, 0));
    end
    build_trace(0, 2 + int'(NC) * (int'(TD) + 1) + 8);
    start_i = 1'b1; tick(); start_i = 1'b0;
    foreach (exp_q[k]) begin
      if (k > 0) tick();
      o = sample();
      checks++;
      if (o !== exp_q[k]) begin
        errors++;
        $display("FAIL wrap cyc%0d: got %s want %s", k, fmt(o), fmt(exp_q[k]));
      end
    end
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    e = exp_q[$];
    e.en = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    o = sample();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL wrap_stop: got %s want %s", fmt(o), fmt(e));
    end
    m_out = e;
  endtask

  task automatic test_random();
    obs_t o;
    obs_t e;
    bit   lp;
    for (int it = 0; it < 3; it++) begin
      for (int a = 0; a < NC; a++) begin
        write_entry(a, mk(16'($urandom), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 5) == 0)));
      end
      lp     = 1'($urandom_range(0, 1));
      loop_i = lp;
      build_trace(lp, 120);
      start_i = 1'b1; tick(); start_i = 1'b0;
      foreach (exp_q[k]) begin
        if (k > 0) tick();
        o = sample();
        checks++;
        if (o !== exp_q[k]) begin
          errors++;
          $display("FAIL random it%0d cyc%0d: got %s want %s", it, k, fmt(o), fmt(exp_q[k]));
        end
      end
      e = exp_q[$];
      if (e.busy) begin
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        e.en = 1'b0; e.busy = 1'b0; e.done = 1'b0;
        o = sample();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL random_stop it%0d: got %s want %s", it, fmt(o), fmt(e));
        end
      end
      loop_i = 1'b0;
      m_out  = e;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rest();
    test_staccato();
    test_loop();
    test_stop_reset();
    test_write_busy();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
